// File: rtl/plic_claim_ctrl.sv
// plic_claim_ctrl: per-source interrupt gateway plus claim/complete sequencer for the 8-source PLIC.
// Optional: define PLIC_SYNC_EN to pass irq_src through a 2-flop synchronizer per bit.
module plic_claim_ctrl #(
  parameter int unsigned NSRC = 8,
  parameter logic [3:0]  NOID = 4'hF
) (
  input  logic            pclk,
  input  logic            preset_n,
  input  logic [NSRC-1:0] irq_src,
  input  logic [NSRC-1:0] irq_en,
  input  logic [NSRC-1:0] irq_edge,
  output logic [NSRC-1:0] IRQ_req,
  input  logic            intr_ev,
  input  logic [3:0]      vecto_no,
  input  logic            I_flag,
  output logic            cpu_irq,
  input  logic            claim_req,
  output logic            claim_ack,
  output logic [3:0]      claim_id,
  input  logic            cmpl_req,
  input  logic [3:0]      cmpl_id,
  output logic            cmpl_ack,
  output logic            cmpl_err,
  output logic [NSRC-1:0] in_service
);

  typedef enum logic [1:0] {IDLE, NOTIFY, SERVICE} state_e;

  state_e          state_q, state_d;
  logic [NSRC-1:0] s;
  logic [NSRC-1:0] s_d_q;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] in_service_q, in_service_d;
  logic [NSRC-1:0] irq_req_q, irq_req_d;
  logic [NSRC-1:0] claim_clr;
  logic [3:0]      active_id_q, active_id_d;
  logic [3:0]      claim_id_q, claim_id_d;
  logic            cpu_irq_q, cpu_irq_d;
  logic            claim_ack_q, claim_ack_d;
  logic            cmpl_ack_q, cmpl_ack_d;
  logic            cmpl_err_q, cmpl_err_d;
  logic            do_claim, do_cmpl;

`ifdef PLIC_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= irq_src;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = irq_src;
`endif

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign do_claim = (state_q == NOTIFY) && claim_req && intr_ev;
  assign do_cmpl  = (state_q == SERVICE) && cmpl_req && (cmpl_id == active_id_q);

  // A claim with a live winner beats withdrawal; a claim without one is answered NOID.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (intr_ev && I_flag) state_d = NOTIFY;
      end
      NOTIFY: begin
        if (claim_req && intr_ev) state_d = SERVICE;
        else if (claim_req || !intr_ev || !I_flag) state_d = IDLE;
      end
      SERVICE: begin
        if (do_cmpl) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    claim_ack_d  = claim_req;
    claim_id_d   = claim_id_q;
    if (claim_req) claim_id_d = do_claim ? vecto_no : NOID;
    cmpl_ack_d   = do_cmpl;
    cmpl_err_d   = cmpl_req && !do_cmpl;
    cpu_irq_d    = (state_d == NOTIFY);
    active_id_d  = do_claim ? vecto_no : active_id_q;
    claim_clr    = do_claim ? ({{(NSRC-1){1'b0}}, 1'b1} << vecto_no) : '0;
    in_service_d = in_service_q;
    if (do_cmpl)  in_service_d = '0;
    if (do_claim) in_service_d = claim_clr;
    // Edge sources keep a new edge even while in service; level sources follow the line.
    pending_d    = (irq_edge & ((s & ~s_d_q) | (pending_q & ~claim_clr)))
                 | (~irq_edge & s & ~in_service_d);
    irq_req_d    = pending_d & irq_en & ~in_service_d;
  end

  always_ff @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      s_d_q        <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      irq_req_q    <= '0;
      active_id_q  <= '0;
      claim_id_q   <= '0;
      cpu_irq_q    <= 1'b0;
      claim_ack_q  <= 1'b0;
      cmpl_ack_q   <= 1'b0;
      cmpl_err_q   <= 1'b0;
    end else begin
      s_d_q        <= s;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      irq_req_q    <= irq_req_d;
      active_id_q  <= active_id_d;
      claim_id_q   <= claim_id_d;
      cpu_irq_q    <= cpu_irq_d;
      claim_ack_q  <= claim_ack_d;
      cmpl_ack_q   <= cmpl_ack_d;
      cmpl_err_q   <= cmpl_err_d;
    end
  end

  assign IRQ_req    = irq_req_q;
  assign cpu_irq    = cpu_irq_q;
  assign claim_ack  = claim_ack_q;
  assign claim_id   = claim_id_q;
  assign cmpl_ack   = cmpl_ack_q;
  assign cmpl_err   = cmpl_err_q;
  assign in_service = in_service_q;

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// tb_plic_claim_ctrl: directed scenarios plus random traffic against a cycle-level behavioural model.
// A lowest-index-wins priority determiner stub closes the loop from IRQ_req to intr_ev/vecto_no.
module tb_plic_claim_ctrl;

  logic       pclk = 1'b0;
  logic       preset_n;
  logic [7:0] irq_src, irq_en, irq_edge;
  logic [7:0] IRQ_req;
  logic       intr_ev;
  logic [3:0] vecto_no;
  logic       I_flag;
  logic       cpu_irq;
  logic       claim_req, claim_ack;
  logic [3:0] claim_id;
  logic       cmpl_req;
  logic [3:0] cmpl_id;
  logic       cmpl_ack, cmpl_err;
  logic [7:0] in_service;

  int total = 0;
  int bad   = 0;

  plic_claim_ctrl dut (
    .pclk(pclk), .preset_n(preset_n),
    .irq_src(irq_src), .irq_en(irq_en), .irq_edge(irq_edge),
    .IRQ_req(IRQ_req), .intr_ev(intr_ev), .vecto_no(vecto_no),
    .I_flag(I_flag), .cpu_irq(cpu_irq),
    .claim_req(claim_req), .claim_ack(claim_ack), .claim_id(claim_id),
    .cmpl_req(cmpl_req), .cmpl_id(cmpl_id),
    .cmpl_ack(cmpl_ack), .cmpl_err(cmpl_err), .in_service(in_service)
  );

  always #5 pclk = ~pclk;

  always_comb begin
    intr_ev  = 1'b0;
    vecto_no = 4'd0;
    for (int i = 7; i >= 0; i--) begin
      if (IRQ_req[i]) begin
        intr_ev  = 1'b1;
        vecto_no = 4'(i);
      end
    end
  end

  // Behavioural model: phase, ID in service (-1 = none), per-source pending and expected outputs.
  typedef enum {M_IDLE, M_NOTIFY, M_SERVICE} mphase_e;
  mphase_e    m_phase;
  int         m_svc;
  bit [7:0]   m_pend, m_prev, m_sy1, m_sy2;
  bit [7:0]   e_irq;
  bit         e_cpu, e_cack, e_mack, e_merr;
  bit [3:0]   e_cid;

`ifdef PLIC_SYNC_EN
  localparam bit SYNC = 1'b1;
`else
  localparam bit SYNC = 1'b0;
`endif

  task automatic modelReset();
    m_phase = M_IDLE;
    m_svc   = -1;
    m_pend  = '0;
    m_prev  = '0;
    m_sy1   = '0;
    m_sy2   = '0;
    e_irq   = '0;
    e_cpu   = 1'b0;
    e_cack  = 1'b0;
    e_mack  = 1'b0;
    e_merr  = 1'b0;
    e_cid   = 4'd0;
  endtask

  task automatic modelStep();
    bit [7:0] s;
    bit       ev;
    int       vec;
    int       claimed;
    int       svc_next;
    mphase_e  nxt;
    ev = 1'b0;
    vec = 0;
    for (int i = 7; i >= 0; i--) begin
      if (e_irq[i]) begin
        ev  = 1'b1;
        vec = i;
      end
    end
    s        = SYNC ? m_sy2 : irq_src;
    claimed  = -1;
    svc_next = m_svc;
    nxt      = m_phase;
    e_cack   = 1'b0;
    e_mack   = 1'b0;
    e_merr   = 1'b0;
    case (m_phase)
      M_IDLE: begin
        if (ev && I_flag) nxt = M_NOTIFY;
        if (claim_req) begin e_cack = 1'b1; e_cid = 4'hF; end
        if (cmpl_req) e_merr = 1'b1;
      end
      M_NOTIFY: begin
        if (claim_req && ev) begin
          claimed = vec; svc_next = vec; nxt = M_SERVICE;
          e_cack = 1'b1; e_cid = 4'(vec);
        end else if (claim_req) begin
          e_cack = 1'b1; e_cid = 4'hF; nxt = M_IDLE;
        end else if (!ev || !I_flag) begin
          nxt = M_IDLE;
        end
        if (cmpl_req) e_merr = 1'b1;
      end
      default: begin
        if (claim_req) begin e_cack = 1'b1; e_cid = 4'hF; end
        if (cmpl_req) begin
          if (int'(cmpl_id) == m_svc) begin
            e_mack = 1'b1; svc_next = -1; nxt = M_IDLE;
          end else begin
            e_merr = 1'b1;
          end
        end
      end
    endcase
    for (int i = 0; i < 8; i++) begin
      if (irq_edge[i]) m_pend[i] = (s[i] && !m_prev[i]) || (m_pend[i] && claimed != i);
      else             m_pend[i] = s[i] && (svc_next != i);
      e_irq[i] = m_pend[i] && irq_en[i] && (svc_next != i);
    end
    e_cpu   = (nxt == M_NOTIFY);
    m_prev  = s;
    m_sy2   = m_sy1;
    m_sy1   = irq_src;
    m_svc   = svc_next;
    m_phase = nxt;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("IRQ_req",    16'(IRQ_req),    16'(e_irq));
    checkOutput("cpu_irq",    16'(cpu_irq),    16'(e_cpu));
    checkOutput("claim_ack",  16'(claim_ack),  16'(e_cack));
    checkOutput("claim_id",   16'(claim_id),   16'(e_cid));
    checkOutput("cmpl_ack",   16'(cmpl_ack),   16'(e_mack));
    checkOutput("cmpl_err",   16'(cmpl_err),   16'(e_merr));
    checkOutput("in_service", 16'(in_service), (m_svc >= 0) ? (16'd1 << m_svc) : 16'd0);
  endtask

  // Called at a falling edge: drive one cycle of inputs, advance the model at the rising edge, check.
  task automatic applyStimulus(input logic [7:0] src, input logic [7:0] en, input logic [7:0] edg,
                               input logic iflag, input logic clm, input logic cmp, input logic [3:0] cid);
    irq_src   = src;
    irq_en    = en;
    irq_edge  = edg;
    I_flag    = iflag;
    claim_req = clm;
    cmpl_req  = cmp;
    cmpl_id   = cid;
    @(posedge pclk);
    modelStep();
    @(negedge pclk);
    checkAll();
  endtask

  task automatic doReset(input bit check_async);
    claim_req = 1'b0;
    cmpl_req  = 1'b0;
    preset_n  = 1'b0;
    modelReset();
    if (check_async) begin
      #1;
      checkAll();
    end
    @(posedge pclk);
    @(negedge pclk);
    checkAll();
    preset_n = 1'b1;
  endtask

  task automatic randomCycle();
    logic [7:0] src;
    logic [3:0] cid;
    src = irq_src ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
    if (m_svc >= 0 && $urandom_range(0, 3) != 0) cid = 4'(m_svc);
    else cid = 4'($urandom);
    applyStimulus(src, irq_en, irq_edge, ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0), cid);
  endtask

  initial begin
    irq_src = '0; irq_en = 8'hFF; irq_edge = '0; I_flag = 1'b1;
    claim_req = 1'b0; cmpl_req = 1'b0; cmpl_id = '0;
    doReset(1'b0);

    // Edge source 3: one-cycle pulse, claim, complete.
    applyStimulus(8'h08, 8'hFF, 8'h08, 1, 0, 0, 0);
    repeat (2) applyStimulus(8'h00, 8'hFF, 8'h08, 1, 0, 0, 0);
    applyStimulus(8'h00, 8'hFF, 8'h08, 1, 1, 0, 0);
    applyStimulus(8'h00, 8'hFF, 8'h08, 1, 0, 0, 0);
    applyStimulus(8'h00, 8'hFF, 8'h08, 1, 0, 1, 3);
    repeat (2) applyStimulus(8'h00, 8'hFF, 8'h08, 1, 0, 0, 0);

    // Level source 5 held through completion, then re-notified and claimed again.
    repeat (3) applyStimulus(8'h20, 8'hFF, 8'h00, 1, 0, 0, 0);
    applyStimulus(8'h20, 8'hFF, 8'h00, 1, 1, 0, 0);
    repeat (2) applyStimulus(8'h20, 8'hFF, 8'h00, 1, 0, 0, 0);
    applyStimulus(8'h20, 8'hFF, 8'h00, 1, 0, 1, 5);
    repeat (4) applyStimulus(8'h20, 8'hFF, 8'h00, 1, 0, 0, 0);
    applyStimulus(8'h20, 8'hFF, 8'h00, 1, 1, 0, 0);
    applyStimulus(8'h00, 8'hFF, 8'h00, 1, 0, 1, 5);
    repeat (3) applyStimulus(8'h00, 8'hFF, 8'h00, 1, 0, 0, 0);

    // Level source 1 withdrawn before the claim: claim answered NOID.
    repeat (2) applyStimulus(8'h02, 8'hFF, 8'h00, 1, 0, 0, 0);
    repeat (3) applyStimulus(8'h00, 8'hFF, 8'h00, 1, 0, 0, 0);
    applyStimulus(8'h00, 8'hFF, 8'h00, 1, 1, 0, 0);
    applyStimulus(8'h00, 8'hFF, 8'h00, 1, 0, 0, 0);

    // Source 2 in service: wrong completion ID, nested claim, then claim and complete together.
    repeat (3) applyStimulus(8'h04, 8'hFF, 8'h00, 1, 0, 0, 0);
    applyStimulus(8'h04, 8'hFF, 8'h00, 1, 1, 0, 0);
    applyStimulus(8'h04, 8'hFF, 8'h00, 1, 0, 1, 6);
    applyStimulus(8'h04, 8'hFF, 8'h00, 1, 1, 0, 0);
    applyStimulus(8'h00, 8'hFF, 8'h00, 1, 1, 1, 2);
    repeat (2) applyStimulus(8'h00, 8'hFF, 8'h00, 1, 0, 0, 0);

    // Global interrupt disable holds off notification of source 0.
    repeat (3) applyStimulus(8'h01, 8'hFF, 8'h00, 0, 0, 0, 0);
    repeat (2) applyStimulus(8'h01, 8'hFF, 8'h00, 1, 0, 0, 0);
    applyStimulus(8'h01, 8'hFF, 8'h00, 1, 1, 0, 0);
    applyStimulus(8'h00, 8'hFF, 8'h00, 1, 0, 1, 0);
    repeat (2) applyStimulus(8'h00, 8'hFF, 8'h00, 1, 0, 0, 0);

    // Reset in the middle of servicing source 5; the still-high line re-notifies afterwards.
    repeat (3) applyStimulus(8'h20, 8'hFF, 8'h00, 1, 0, 0, 0);
    applyStimulus(8'h20, 8'hFF, 8'h00, 1, 1, 0, 0);
    applyStimulus(8'h20, 8'hFF, 8'h00, 1, 0, 0, 0);
    doReset(1'b1);
    repeat (4) applyStimulus(8'h20, 8'hFF, 8'h00, 1, 0, 0, 0);
    applyStimulus(8'h20, 8'hFF, 8'h00, 1, 1, 0, 0);
    applyStimulus(8'h00, 8'hFF, 8'h00, 1, 0, 1, 5);
    repeat (2) applyStimulus(8'h00, 8'hFF, 8'h00, 1, 0, 0, 0);

    // Random traffic with mode/enable reshuffles and occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if (n % 100 == 0) begin
        irq_edge = 8'($urandom);
        irq_en   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'hFF;
      end
      if ($urandom_range(0, 299) == 0) doReset(1'b1);
      else randomCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
